// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings and stage-control constants for the pipeline stall/flush scheduler.
package pipeline_ctrl_pkg;

    localparam int unsigned NUM_STAGES = 4;

    localparam int unsigned STG_IFID  = 0;
    localparam int unsigned STG_IDEX  = 1;
    localparam int unsigned STG_EXMEM = 2;
    localparam int unsigned STG_MEMWB = 3;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_MC_WAIT = 2'd2
    } sched_state_e;

    // Per-cycle control word applied to the stage registers and the PC.
    typedef struct packed {
        logic [NUM_STAGES-1:0] lock;
        logic [NUM_STAGES-1:0] clear;
        logic                  pc_write;
    } stage_ctrl_t;

    localparam logic [NUM_STAGES-1:0] LOCK_ALL   = 4'b1111;
    localparam logic [NUM_STAGES-1:0] CLEAR_NONE = 4'b0000;

    localparam logic [NUM_STAGES-1:0] LOCK_RESET      = 4'b0000;
    localparam logic [NUM_STAGES-1:0] CLEAR_RESET     = 4'b1111;
    localparam logic [NUM_STAGES-1:0] LOCK_BRANCH     = 4'b1100;
    localparam logic [NUM_STAGES-1:0] CLEAR_BRANCH    = 4'b0011;
    localparam logic [NUM_STAGES-1:0] LOCK_MC         = 4'b1000;
    localparam logic [NUM_STAGES-1:0] CLEAR_MC        = 4'b1000;
    localparam logic [NUM_STAGES-1:0] LOCK_LOAD_USE   = 4'b1110;
    localparam logic [NUM_STAGES-1:0] CLEAR_LOAD_USE  = 4'b0010;
    localparam logic [NUM_STAGES-1:0] LOCK_FLUSH      = LOCK_ALL;
    localparam logic [NUM_STAGES-1:0] CLEAR_FLUSH     = 4'b0011;

    localparam stage_ctrl_t CTRL_IDLE     = {LOCK_ALL,      CLEAR_NONE,     1'b1};
    localparam stage_ctrl_t CTRL_RESET    = {LOCK_RESET,    CLEAR_RESET,    1'b0};
    localparam stage_ctrl_t CTRL_BRANCH   = {LOCK_BRANCH,   CLEAR_BRANCH,   1'b1};
    localparam stage_ctrl_t CTRL_MC       = {LOCK_MC,       CLEAR_MC,       1'b0};
    localparam stage_ctrl_t CTRL_LOAD_USE = {LOCK_LOAD_USE, CLEAR_LOAD_USE, 1'b0};
    localparam stage_ctrl_t CTRL_FLUSH    = {LOCK_FLUSH,    CLEAR_FLUSH,    1'b1};

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare between the load in ID/EX and the sources in IF/ID; r0 never hazards.
module load_use_detect #(
    parameter int unsigned REG_W = 5
) (
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rd,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    output logic             hazard_c
);

    assign hazard_c = ex_memread && (ex_rd != '0) && ((ex_rd == id_rs) || (ex_rd == id_rt));

endmodule

// File: rtl/pipeline_hazard_sched.sv
// Central stall/flush scheduler: arbitrates branch flush, multi-cycle freeze and load-use bubble,
// drives per-stage lock/clear and PC write, and keeps saturating stall/flush statistics.
module pipeline_hazard_sched
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned REG_W        = 5,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned MC_TIMEOUT   = 64,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  branch_taken,
    input  logic                  mc_start,
    input  logic                  mc_done,
    input  logic                  ex_memread,
    input  logic [REG_W-1:0]      ex_rd,
    input  logic [REG_W-1:0]      id_rs,
    input  logic [REG_W-1:0]      id_rt,
    output logic [NUM_STAGES-1:0] pipeline_lock,
    output logic [NUM_STAGES-1:0] pipeline_clear,
    output logic                  pc_write,
    output logic                  mc_timeout,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_cycles
);

    localparam int unsigned FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int unsigned MC_W    = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;

    sched_state_e       state_q, state_d;
    logic [FLUSH_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [MC_W-1:0]    mc_cnt_q, mc_cnt_d;
    logic               mc_timeout_d;
    logic [CNT_W-1:0]   stall_cycles_d, flush_cycles_d;
    logic               stall_inc, flush_inc;
    logic               load_use_c;
    stage_ctrl_t        ctrl_c;

    load_use_detect #(
        .REG_W (REG_W)
    ) u_load_use_detect (
        .ex_memread (ex_memread),
        .ex_rd      (ex_rd),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .hazard_c   (load_use_c)
    );

    // Next-state, counter and same-cycle output decode.
    always_comb begin
        state_d      = state_q;
        flush_cnt_d  = flush_cnt_q;
        mc_cnt_d     = mc_cnt_q;
        mc_timeout_d = mc_timeout;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        ctrl_c       = CTRL_IDLE;

        unique case (state_q)
            ST_RUN: begin
                if (branch_taken) begin
                    ctrl_c    = CTRL_BRANCH;
                    flush_inc = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d     = ST_FLUSH;
                        flush_cnt_d = FLUSH_W'(FLUSH_CYCLES - 1);
                    end
                end else if (mc_start) begin
                    ctrl_c    = CTRL_MC;
                    stall_inc = 1'b1;
                    state_d   = ST_MC_WAIT;
                    mc_cnt_d  = '0;
                end else if (load_use_c) begin
                    ctrl_c    = CTRL_LOAD_USE;
                    stall_inc = 1'b1;
                end
            end
            ST_FLUSH: begin
                ctrl_c    = CTRL_FLUSH;
                flush_inc = 1'b1;
                if (branch_taken) begin
                    flush_cnt_d = FLUSH_W'(FLUSH_CYCLES - 1);
                end else if (flush_cnt_q <= FLUSH_W'(1)) begin
                    state_d = ST_RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q - FLUSH_W'(1);
                end
            end
            ST_MC_WAIT: begin
                if (mc_done) begin
                    state_d = ST_RUN;
                end else begin
                    ctrl_c    = CTRL_MC;
                    stall_inc = 1'b1;
                    // Counter is about to reach MC_TIMEOUT-1: give up on the unit.
                    if (mc_cnt_q == MC_W'(MC_TIMEOUT - 2)) begin
                        mc_timeout_d = 1'b1;
                        state_d      = ST_RUN;
                    end else begin
                        mc_cnt_d = mc_cnt_q + MC_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (reset) begin
            ctrl_c = CTRL_RESET;
        end
    end

    // Saturating statistics.
    always_comb begin
        stall_cycles_d = stall_cycles;
        flush_cycles_d = flush_cycles;
        if (stall_inc && (stall_cycles != '1)) begin
            stall_cycles_d = stall_cycles + CNT_W'(1);
        end
        if (flush_inc && (flush_cycles != '1)) begin
            flush_cycles_d = flush_cycles + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_RUN;
            flush_cnt_q  <= '0;
            mc_cnt_q     <= '0;
            mc_timeout   <= 1'b0;
            stall_cycles <= '0;
            flush_cycles <= '0;
        end else begin
            state_q      <= state_d;
            flush_cnt_q  <= flush_cnt_d;
            mc_cnt_q     <= mc_cnt_d;
            mc_timeout   <= mc_timeout_d;
            stall_cycles <= stall_cycles_d;
            flush_cycles <= flush_cycles_d;
        end
    end

    assign pipeline_lock  = ctrl_c.lock;
    assign pipeline_clear = ctrl_c.clear;
    assign pc_write       = ctrl_c.pc_write;

endmodule

// File: tb/tb_pipeline_hazard_sched.sv
// Randomized scoreboard bench for pipeline_hazard_sched against a cycle-level behavioural model.
module tb_pipeline_hazard_sched;

    localparam int unsigned REG_W = 5;
    localparam int unsigned FC    = 3;
    localparam int unsigned MCT   = 8;
    localparam int unsigned CW    = 6;
    localparam int          CMAX  = (1 << CW) - 1;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             branch_taken = 1'b0;
    logic             mc_start = 1'b0;
    logic             mc_done = 1'b0;
    logic             ex_memread = 1'b0;
    logic [REG_W-1:0] ex_rd = '0;
    logic [REG_W-1:0] id_rs = '0;
    logic [REG_W-1:0] id_rt = '0;
    logic [3:0]       pipeline_lock;
    logic [3:0]       pipeline_clear;
    logic             pc_write;
    logic             mc_timeout;
    logic [CW-1:0]    stall_cycles;
    logic [CW-1:0]    flush_cycles;

    pipeline_hazard_sched #(
        .REG_W        (REG_W),
        .FLUSH_CYCLES (FC),
        .MC_TIMEOUT   (MCT),
        .CNT_W        (CW)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .branch_taken   (branch_taken),
        .mc_start       (mc_start),
        .mc_done        (mc_done),
        .ex_memread     (ex_memread),
        .ex_rd          (ex_rd),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .pipeline_lock  (pipeline_lock),
        .pipeline_clear (pipeline_clear),
        .pc_write       (pc_write),
        .mc_timeout     (mc_timeout),
        .stall_cycles   (stall_cycles),
        .flush_cycles   (flush_cycles)
    );

    always #5 clock = ~clock;

    typedef struct {
        int lock;
        int clear;
        int pc;
        int stall;
        int flush;
        int tmo;
        bit chk_regs;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Model state: remaining forced-flush cycles, frozen cycles so far (0 = not waiting).
    int m_flush_left = 0;
    int m_frozen     = 0;
    int m_stall      = 0;
    int m_flush      = 0;
    int m_tmo        = 0;
    bit m_known      = 1'b0;

    task automatic cmp(input string nm, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", nm, cyc, act, exp_v);
        end
    endtask

    function automatic int sat_add(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic step(input logic br, input logic ms, input logic md, input logic mr,
                        input int rd, input int rs, input int rt, input logic rst);
        exp_t e;
        bit   lu;
        branch_taken = br;
        mc_start     = ms;
        mc_done      = md;
        ex_memread   = mr;
        ex_rd        = REG_W'(rd);
        id_rs        = REG_W'(rs);
        id_rt        = REG_W'(rt);
        reset        = rst;
        lu = mr && (rd != 0) && (rd == rs || rd == rt);
        e.stall = m_stall;
        e.flush = m_flush;
        e.tmo = m_tmo;
        e.chk_regs = m_known;
        e.lock = 4'b1111;
        e.clear = 4'b0000;
        e.pc = 1;
        if (rst) begin
            e.lock = 4'b0000;
            e.clear = 4'b1111;
            e.pc = 0;
            m_flush_left = 0;
            m_frozen = 0;
            m_stall = 0;
            m_flush = 0;
            m_tmo = 0;
            m_known = 1'b1;
        end else if (m_flush_left > 0) begin
            e.clear = 4'b0011;
            m_flush = sat_add(m_flush);
            m_flush_left = br ? FC - 1 : m_flush_left - 1;
        end else if (m_frozen > 0) begin
            if (md) begin
                m_frozen = 0;
            end else begin
                e.lock = 4'b1000;
                e.clear = 4'b1000;
                e.pc = 0;
                m_stall = sat_add(m_stall);
                m_frozen++;
                if (m_frozen == MCT) begin
                    m_tmo = 1;
                    m_frozen = 0;
                end
            end
        end else if (br) begin
            e.lock = 4'b1100;
            e.clear = 4'b0011;
            m_flush = sat_add(m_flush);
            m_flush_left = FC - 1;
        end else if (ms) begin
            e.lock = 4'b1000;
            e.clear = 4'b1000;
            e.pc = 0;
            m_stall = sat_add(m_stall);
            m_frozen = 1;
        end else if (lu) begin
            e.lock = 4'b1110;
            e.clear = 4'b0010;
            e.pc = 0;
            m_stall = sat_add(m_stall);
        end
        sb.push_back(e);
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    // Monitor: the DUT presents a control word every cycle; compare mid-cycle.
    always @(negedge clock) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            cmp("lock", int'(pipeline_lock), e.lock);
            cmp("clear", int'(pipeline_clear), e.clear);
            cmp("pc_write", int'(pc_write), e.pc);
            if (e.chk_regs) begin
                cmp("stall_cycles", int'(stall_cycles), e.stall);
                cmp("flush_cycles", int'(flush_cycles), e.flush);
                cmp("mc_timeout", int'(mc_timeout), e.tmo);
            end
        end
        cyc++;
    end

    initial begin
        @(posedge clock);
        #1;
        do_reset(1);

        // Reset held two cycles in the middle of a multi-cycle wait.
        step(0, 1, 0, 0, 0, 0, 0, 0);
        idle(2);
        do_reset(2);
        cmp("rst_stall", int'(stall_cycles), 0);
        cmp("rst_tmo", int'(mc_timeout), 0);
        idle(1);

        // Load-use bubble, then the same pattern against r0.
        step(0, 0, 0, 1, 5, 5, 9, 0);
        cmp("lu_stall", int'(stall_cycles), 1);
        step(0, 0, 0, 1, 0, 0, 0, 0);
        cmp("lu_r0_stall", int'(stall_cycles), 1);
        idle(1);

        // Single branch, then a branch re-armed inside the flush window.
        do_reset(1);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        idle(3);
        cmp("flush_single", int'(flush_cycles), 3);
        do_reset(1);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        idle(3);
        cmp("flush_rearm", int'(flush_cycles), 5);

        // Multi-cycle op completing on the seventh frozen cycle, branches ignored meanwhile.
        do_reset(1);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(i[0], 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0);
        cmp("mc_stall", int'(stall_cycles), 7);
        cmp("mc_no_tmo", int'(mc_timeout), 0);
        cmp("mc_no_flush", int'(flush_cycles), 0);
        idle(2);

        // All three events together: branch wins.
        do_reset(1);
        step(1, 1, 0, 1, 3, 3, 3, 0);
        cmp("prio_stall", int'(stall_cycles), 0);
        cmp("prio_flush", int'(flush_cycles), 1);
        idle(3);

        // Timeout with no completion, sticky until reset.
        do_reset(1);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        idle(7);
        cmp("tmo_set", int'(mc_timeout), 1);
        cmp("tmo_stall", int'(stall_cycles), 8);
        step(0, 0, 1, 0, 0, 0, 0, 0);
        idle(4);
        cmp("tmo_sticky", int'(mc_timeout), 1);
        do_reset(1);
        cmp("tmo_clear", int'(mc_timeout), 0);

        // Random traffic; small register range to provoke hazards, counters saturate.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0,
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 7)), $urandom_range(0, 299) == 0);
        end

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clock);
        if (sb.size() > 0) begin
            bad++;
            $display("FAIL drain pending=%0d expected=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_sched.md
Name: pipeline_hazard_sched

Overview:
Central stall/flush scheduler for the 4-stage pipelined processor. It drives the per-stage write-enable (`pipeline_lock`) and synchronous-zero (`pipeline_clear`) vectors, plus the PC write enable. It arbitrates between three event sources:
- taken branches (flush)
- multi-cycle EX operations (freeze)
- load-use hazards (bubble)

It also keeps saturating stall and flush statistics. It sits beside the stage registers, in place of the simple branch-only lock/clear decoder.

Parameters:
- `REG_W`, 5, register-address width for hazard compare.
- `FLUSH_CYCLES`, 1, number of cycles of front-end clear per taken branch (≥1).
- `MC_TIMEOUT`, 64, maximum cycles in MC_WAIT before forced exit.
- `CNT_W`, 16, width of the statistics counters.

Ports:
- `clock` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `branch_taken` in 1: branch resolved taken in EX this cycle.
- `mc_start` in 1: multi-cycle op (mul/div) enters EX this cycle.
- `mc_done` in 1: multi-cycle unit result valid.
- `ex_memread` in 1: instruction in ID/EX is a load.
- `ex_rd` in `REG_W`: destination of the instruction in ID/EX.
- `id_rs` in `REG_W`: source 1 of the instruction in IF/ID.
- `id_rt` in `REG_W`: source 2 of the instruction in IF/ID.
- `pipeline_lock` out 4: per-stage register write enable (1 = write, 0 = hold).
- `pipeline_clear` out 4: per-stage register clear (1 = zero, 0 = keep).
- `pc_write` out 1: PC update enable.
- `mc_timeout` out 1: sticky error flag.
- `stall_cycles` out `CNT_W`: count of stall cycles.
- `flush_cycles` out `CNT_W`: count of flush cycles.

Behaviour:
- Bit map: bit0 = IF/ID, bit1 = ID/EX, bit2 = EX/MEM, bit3 = MEM/WB. At a stage register, clear overrides lock.
- Clock and reset: one clock. Reset is synchronous and active-high.
- During reset (cycle-level):
  - `lock` = 4'b0000, `clear` = 4'b1111, `pc_write` = 0.
  - Next state = RUN.
  - Flush counter = 0, MC counter = 0.
  - `mc_timeout` = 0, `stall_cycles` = 0, `flush_cycles` = 0.
  - Reset mid-FLUSH or mid-MC_WAIT aborts immediately to RUN.
- Outputs are combinational from the registered state and the current inputs, so bubbles and flushes take effect the same cycle.
- Load-use condition: `ex_memread` && `ex_rd` != 0 && (`ex_rd` == `id_rs` || `ex_rd` == `id_rt`).
- FSM states: RUN, FLUSH, MC_WAIT.
- RUN, fixed priority branch > mc > load-use:
  - `branch_taken`: `lock` = 4'b1100, `clear` = 4'b0011, `pc_write` = 1. If `FLUSH_CYCLES` > 1, go to FLUSH with counter = `FLUSH_CYCLES`-1; otherwise stay in RUN. `flush_cycles` += 1.
  - `mc_start`: `lock` = 4'b1000, `clear` = 4'b1000, `pc_write` = 0. Go to MC_WAIT with MC counter = 0. `stall_cycles` += 1.
  - Load-use: `lock` = 4'b1110, `clear` = 4'b0010, `pc_write` = 0. Stay in RUN; the one-cycle stall resolves naturally. `stall_cycles` += 1.
  - None of the above: `lock` = 4'b1111, `clear` = 4'b0000, `pc_write` = 1.
- FLUSH:
  - Outputs: `lock` = 4'b1111, `clear` = 4'b0011, `pc_write` = 1. `flush_cycles` += 1.
  - Counter decrements each cycle; exit to RUN when it reaches 1.
  - A new `branch_taken` in FLUSH reloads the counter to `FLUSH_CYCLES`-1.
  - `mc_start` and load-use are ignored in FLUSH (their instructions are being cleared).
- MC_WAIT:
  - Outputs: `lock` = 4'b1000, `clear` = 4'b1000, `pc_write` = 0.
  - `branch_taken` is ignored, because EX is frozen.
  - `mc_done`: output RUN-idle values this cycle (`lock` = 4'b1111, `clear` = 4'b0000, `pc_write` = 1) and go to RUN. This cycle is not counted as a stall.
  - Otherwise `stall_cycles` += 1 and the MC counter increments.
  - When the MC counter reaches `MC_TIMEOUT`-1 without `mc_done`: set `mc_timeout` (sticky until reset) and go to RUN.
  - `mc_done` in the same cycle as the timeout wins, and `mc_timeout` is not set.
- `mc_done` outside MC_WAIT is ignored.
- Statistics counters saturate at all-ones; no wrap.

Decomposition:
- Shared package `pipeline_ctrl_pkg` holds:
  - the state encoding (RUN = 2'd0, FLUSH = 2'd1, MC_WAIT = 2'd2)
  - stage bit indices `STG_IFID` through `STG_MEMWB`
  - vector constants `LOCK_ALL` = 4'b1111 and `CLEAR_NONE` = 4'b0000
  - the per-event lock/clear constants listed under Behaviour.
- One sub-module, `load_use_detect`, holds the combinational hazard compare with the r0 exclusion.
- The FSM, counters and output mux stay in the top.

Test Plan:
- Reset held 2 cycles, mid-MC_WAIT → `lock` = 0000, `clear` = 1111, `pc_write` = 0 during reset. Afterwards state is RUN, `lock` = 1111, `clear` = 0000, counters = 0, `mc_timeout` = 0.
- `ex_memread` = 1, `ex_rd` = 5, `id_rs` = 5 for 1 cycle → `lock` = 1110, `clear` = 0010, `pc_write` = 0, `stall_cycles` = 1. Repeat with `ex_rd` = 0 → no stall.
- `FLUSH_CYCLES` = 3, `branch_taken` pulse → `clear` = 0011 for 3 consecutive cycles, `flush_cycles` = 3. A second branch on cycle 2 → 3 further flush cycles from that point, total 5.
- `mc_start`, then `mc_done` after 7 cycles → `lock` = 1000, `clear` = 1000, `pc_write` = 0 for 7 cycles. The `mc_done` cycle shows 1111/0000 and state returns to RUN. `stall_cycles` = 7. `branch_taken` asserted during the wait has no effect.
- Simultaneous `branch_taken`, `mc_start` and load-use in RUN → branch outputs 1100/0011, `pc_write` = 1. No MC_WAIT entry, `stall_cycles` unchanged.
- `MC_TIMEOUT` = 8, `mc_start` with no `mc_done` → RUN after 8 frozen cycles, `mc_timeout` = 1 and it stays 1 until reset.
